ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, consuming the operands, funct and Rd held in the ID/EX pipeline register. It accepts one M-extension operation at a time, computes it over 32 iteration cycles, and drives a combinational stall so that ID/EX and earlier stages hold their contents until the result is ready. The result and Rd are handed to the EX/MEM register in a single-cycle done slot.

---
 rtl/ex_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_unit                                               |
// | Description : Iterative RV32M multiply/divide unit for the EX stage.        |
// |               32-cycle shift-add multiply and restoring divide, with a      |
// |               combinational stall to hold ID/EX and a one-cycle done slot.  |
// | Config      : define MULDIV_DIV_EN to include the divider datapath; when it |
// |               is absent, DIV/DIVU/REM/REMU finish at once with err_o=1.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ex_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        sign_q, sign_d;
  // hi: product upper half / partial remainder
  // lo: multiplier + product lower half / dividend shifting into quotient
  // b : multiplicand / divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;

  // Operand signedness and result sign for the op presented in ID/EX
  logic        op1_signed, op2_signed, res_sign;
  logic [31:0] mag1, mag2;

  // Classify the incoming op and take operand magnitudes
  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    res_sign   = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
        res_sign   = op1_i[31] ^ op2_i[31];
      end
      3'b010: begin
        op1_signed = 1'b1;
        res_sign   = op1_i[31];
      end
      3'b110: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
        res_sign   = op1_i[31];
      end
      default: begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        res_sign   = 1'b0;
      end
    endcase
    mag1 = (op1_signed && op1_i[31]) ? (~op1_i + 32'd1) : op1_i;
    mag2 = (op2_signed && op2_i[31]) ? (~op2_i + 32'd1) : op2_i;
  end

  // One shift-add multiply step and the final sign-corrected product
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [63:0] prod_fix;
  logic [31:0] mul_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : 32'd0)};
    mul_hi   = mul_sum[32:1];
    mul_lo   = {mul_sum[0], lo_q[31:1]};
    prod_fix = sign_q ? (~{mul_hi, mul_lo} + 64'd1) : {mul_hi, mul_lo};
    mul_res  = (funct3_q == 3'b000) ? prod_fix[31:0] : prod_fix[63:32];
  end

`ifdef MULDIV_DIV_EN
  // One restoring-divide step and the final sign-corrected quotient/remainder
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] div_hi, div_lo, div_sel, div_res;

  always_comb begin
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[32];
    div_hi    = div_ge ? div_diff[31:0] : div_shift[31:0];
    div_lo    = {lo_q[30:0], div_ge};
    div_sel   = funct3_q[1] ? div_hi : div_lo;
    div_res   = sign_q ? (~div_sel + 32'd1) : div_sel;
  end
`endif

  // Select step and final result by op class
  logic [31:0] step_hi, step_lo, final_res;

  always_comb begin
`ifdef MULDIV_DIV_EN
    step_hi   = funct3_q[2] ? div_hi  : mul_hi;
    step_lo   = funct3_q[2] ? div_lo  : mul_lo;
    final_res = funct3_q[2] ? div_res : mul_res;
`else
    step_hi   = mul_hi;
    step_lo   = mul_lo;
    final_res = mul_res;
`endif
  end

  // Ops that finish without iterating, and their results
  logic        special;
  logic        special_err;
  logic [31:0] special_res;

  always_comb begin
    special     = 1'b0;
    special_err = 1'b0;
    special_res = 32'd0;
`ifdef MULDIV_DIV_EN
    if (funct3_i[2] && (op2_i == 32'd0)) begin
      special     = 1'b1;
      special_res = funct3_i[1] ? op1_i : 32'hFFFF_FFFF;
    end else if (funct3_i[2] && !funct3_i[0] &&
                 (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF)) begin
      special     = 1'b1;
      special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    if (funct3_i[2]) begin
      special     = 1'b1;
      special_err = 1'b1;
      special_res = 32'd0;
    end
`endif
  end

  // Next-state and datapath update; flush wins over everything else
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    funct3_d = funct3_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            funct3_d = funct3_i;
            rd_d     = rd_i;
            sign_d   = res_sign;
            hi_d     = 32'd0;
            lo_d     = mag1;
            b_d      = mag2;
            count_d  = 5'd0;
            err_d    = 1'b0;
            if (special) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = special_res;
              err_d    = special_err;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = final_res;
          end
        end
        default: begin
          // Same instruction still sits in ID/EX here, so valid_i is ignored
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      funct3_q <= 3'd0;
      sign_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      funct3_q <= funct3_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign stall_o  = ((state_q == ST_IDLE) & valid_i & ~flush_i) |
                    ((state_q == ST_RUN) & ~flush_i);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_unit                                            |
// | Description : Directed self-checking bench for ex_muldiv_unit.             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        err_o;

  int          checks = 0;
  int          errors = 0;

  int          cyc, stl, seen;
  logic [31:0] res;
  logic [4:0]  rdo;
  logic        err;

  ex_muldiv_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .funct3_i (funct3_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op and hold it until done_o; cycle 1 is the valid_i cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int c, output int s,
                        output logic [31:0] r, output logic [4:0] ro, output logic e);
    @(negedge clk_i);
    funct3_i = f; op1_i = a; op2_i = b; rd_i = rd; valid_i = 1'b1;
    c = 0; s = 0; r = 32'hDEAD_BEEF; ro = 5'h1F; e = 1'bx;
    for (int n = 1; n <= 100; n++) begin
      #1;
      if (done_o) begin
        c = n; r = result_o; ro = rd_o; e = err_o;
        break;
      end
      if (stall_o) s++;
      @(negedge clk_i);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op1_i = 32'd0; op2_i = 32'd0; rd_i = 5'd0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_done",   {31'd0, done_o}, 32'd0);
    chk("rst_err",    {31'd0, err_o},  32'd0);
    chk("rst_result", result_o,        32'd0);
    chk("rst_rd",     {27'd0, rd_o},   32'd0);
    chk("rst_stall",  {31'd0, stall_o}, 32'd0);
    valid_i = 1'b1;
    #1;
    chk("rst_stall_valid", {31'd0, stall_o}, 32'd1);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // MUL 7 x -3
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd11, cyc, stl, res, rdo, err);
    chk("mul_cycles", cyc, 34);
    chk("mul_stall",  stl, 33);
    chk("mul_result", res, 32'hFFFF_FFEB);
    chk("mul_rd",     {27'd0, rdo}, 32'd11);
    chk("mul_err",    {31'd0, err}, 32'd0);
    @(negedge clk_i);
    #1;
    chk("done_pulse", {31'd0, done_o}, 32'd0);

    // MULH / MULHU on all-ones operands
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, cyc, stl, res, rdo, err);
    chk("mulh_result", res, 32'h0000_0000);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, cyc, stl, res, rdo, err);
    chk("mulhu_result", res, 32'hFFFF_FFFE);
    chk("mulhu_cycles", cyc, 34);

    // MULHSU -2 x 3 = -6, high word all ones
    run_op(3'b010, 32'hFFFF_FFFE, 32'd3, 5'd5, cyc, stl, res, rdo, err);
    chk("mulhsu_result", res, 32'hFFFF_FFFF);

`ifdef MULDIV_DIV_EN
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, cyc, stl, res, rdo, err);
    chk("div_result", res, 32'hFFFF_FFFD);
    chk("div_cycles", cyc, 34);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, cyc, stl, res, rdo, err);
    chk("rem_result", res, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd0, 5'd8, cyc, stl, res, rdo, err);
    chk("divz_result", res, 32'hFFFF_FFFF);
    chk("divz_stall",  stl, 1);
    chk("divz_cycles", cyc, 2);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, cyc, stl, res, rdo, err);
    chk("ovf_div_result", res, 32'h8000_0000);
    chk("ovf_div_stall",  stl, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, cyc, stl, res, rdo, err);
    chk("ovf_rem_result", res, 32'h0000_0000);
    chk("ovf_rem_err",    {31'd0, err}, 32'd0);
`else
    run_op(3'b101, 32'd9, 32'd3, 5'd12, cyc, stl, res, rdo, err);
    chk("nodiv_cycles", cyc, 2);
    chk("nodiv_stall",  stl, 1);
    chk("nodiv_err",    {31'd0, err}, 32'd1);
    chk("nodiv_result", res, 32'd0);
    chk("nodiv_rd",     {27'd0, rdo}, 32'd12);
`endif

    // Flush at RUN count 10 (cycle 12 counting the valid_i cycle as 1)
    @(negedge clk_i);
    funct3_i = 3'b000; op1_i = 32'd123; op2_i = 32'd456; rd_i = 5'd13; valid_i = 1'b1;
    repeat (11) @(negedge clk_i);
    #1;
    chk("flush_pre_stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      #1;
      if (done_o) seen = 1;
    end
    chk("flush_no_done", seen, 0);

    // Reset pulsed in the middle of a multiply
    @(negedge clk_i);
    funct3_i = 3'b000; op1_i = 32'd1000; op2_i = 32'd1000; rd_i = 5'd14; valid_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #2;
    valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midrst_done",   {31'd0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd",     {27'd0, rd_o}, 32'd0);
    chk("midrst_stall",  {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(3'b000, 32'd3, 32'd5, 5'd15, cyc, stl, res, rdo, err);
    chk("post_rst_result", res, 32'd15);
    chk("post_rst_rd",     {27'd0, rdo}, 32'd15);
    chk("post_rst_cycles", cyc, 34);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
